// File: rtl/kbfifo_pkg.sv
// Shared defaults, operation decode and sizing helper for the keyboard/input-event FIFO.
package kbfifo_pkg;

    localparam int unsigned DefaultWidth     = 16;
    localparam int unsigned DefaultDepthLog2 = 4;

    // Effective pointer operation for one cycle: {push, pop}.
    typedef enum logic [1:0] {
        OpIdle    = 2'b00,
        OpPop     = 2'b01,
        OpPush    = 2'b10,
        OpPushPop = 2'b11
    } kbfifo_op_e;

    // Occupancy needs one extra bit so that a completely full FIFO is representable.
    function automatic int unsigned count_width(input int unsigned depth_log2);
        return depth_log2 + 1;
    endfunction

endpackage

// File: rtl/kbfifo_if.sv
// Producer/consumer-side bundle for kbfifo; master drives requests, slave is the FIFO.
interface kbfifo_if
    import kbfifo_pkg::*;
#(
    parameter int unsigned WIDTH      = DefaultWidth,
    parameter int unsigned DEPTH_LOG2 = DefaultDepthLog2
) ();

    logic [WIDTH-1:0]      wrdata;
    logic                  wr_en;
    logic                  flush;
    logic                  rd_en;
    logic [WIDTH-1:0]      rddata;
    logic                  rd_empty;
    logic [DEPTH_LOG2:0]   count;
    logic                  full;
    logic                  overflow;

    modport master (
        output wrdata, wr_en, flush, rd_en,
        input  rddata, rd_empty, count, full, overflow
    );

    modport slave (
        input  wrdata, wr_en, flush, rd_en,
        output rddata, rd_empty, count, full, overflow
    );

endinterface

// File: rtl/kbfifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read into the caller's register.
module kbfifo_ram #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/kbfifo.sv
// Parametrised synchronous FIFO with registered pop, occupancy count and flush.
// Define KBFIFO_OVERFLOW_EN to build the sticky dropped-write flag; otherwise overflow is 0.
module kbfifo
    import kbfifo_pkg::*;
#(
    parameter int unsigned WIDTH      = DefaultWidth,
    parameter int unsigned DEPTH_LOG2 = DefaultDepthLog2
) (
    input logic     clk,
    input logic     rst,
    kbfifo_if.slave bus
);

    localparam int unsigned CntW = count_width(DEPTH_LOG2);
    localparam logic [CntW-1:0] PtrOne = {{(CntW-1){1'b0}}, 1'b1};

    logic [CntW-1:0]  r_wrptr;
    logic [CntW-1:0]  r_rdptr;
    logic [CntW-1:0]  r_count;
    logic [WIDTH-1:0] r_rddata;
    logic             r_rd_empty;

    logic [CntW-1:0]  w_wrptr_d;
    logic [CntW-1:0]  w_rdptr_d;
    logic [WIDTH-1:0] w_head;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    kbfifo_op_e       w_op;

    // Extra MSB distinguishes full from empty when the low address bits coincide.
    assign w_empty = (r_wrptr == r_rdptr);
    assign w_full  = (r_wrptr[CntW-2:0] == r_rdptr[CntW-2:0])
                  && (r_wrptr[CntW-1] != r_rdptr[CntW-1]);

    assign w_push = bus.wr_en && !w_full && !bus.flush;
    assign w_pop  = bus.rd_en && !w_empty && !bus.flush;
    assign w_op   = kbfifo_op_e'({w_push, w_pop});

    always_comb begin
        w_wrptr_d = r_wrptr;
        w_rdptr_d = r_rdptr;
        if (bus.flush) begin
            w_wrptr_d = '0;
            w_rdptr_d = '0;
        end else begin
            unique case (w_op)
                OpIdle:    ;
                OpPop:     w_rdptr_d = r_rdptr + PtrOne;
                OpPush:    w_wrptr_d = r_wrptr + PtrOne;
                OpPushPop: begin
                    w_wrptr_d = r_wrptr + PtrOne;
                    w_rdptr_d = r_rdptr + PtrOne;
                end
            endcase
        end
    end

    kbfifo_ram #(
        .WIDTH  (WIDTH),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wrptr[CntW-2:0]),
        .i_wdata (bus.wrdata),
        .i_raddr (r_rdptr[CntW-2:0]),
        .o_rdata (w_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrptr    <= '0;
            r_rdptr    <= '0;
            r_count    <= '0;
            r_rddata   <= '0;
            r_rd_empty <= 1'b1;
        end else begin
            r_wrptr <= w_wrptr_d;
            r_rdptr <= w_rdptr_d;
            r_count <= w_wrptr_d - w_rdptr_d;
            // Flush leaves the last pop result visible.
            if (bus.rd_en && !bus.flush) begin
                r_rddata   <= w_empty ? '0 : w_head;
                r_rd_empty <= w_empty;
            end
        end
    end

`ifdef KBFIFO_OVERFLOW_EN
    logic r_overflow;

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_overflow <= 1'b0;
        end else if (bus.wr_en && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    assign bus.overflow = r_overflow;
`else
    assign bus.overflow = 1'b0;
`endif

    assign bus.rddata   = r_rddata;
    assign bus.rd_empty = r_rd_empty;
    assign bus.count    = r_count;
    assign bus.full     = w_full;

endmodule

// File: tb/tb_kbfifo.sv
// Self-checking bench for kbfifo: queue-based scoreboard, one task per scenario.
module tb_kbfifo;

    localparam int Depth = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    kbfifo_if #(.WIDTH(16), .DEPTH_LOG2(4)) bus ();

    kbfifo #(
        .WIDTH      (16),
        .DEPTH_LOG2 (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] sb[$];
    logic [15:0] exp_rd;
    logic        exp_empty;
    logic        m_ovf;
    int          errors = 0;
    int          checks = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    // Apply one cycle of stimulus and advance the scoreboard using pre-edge occupancy.
    task automatic op(input logic wr, input logic [15:0] wd, input logic rd, input logic fl);
        bit full_pre;
        bit empty_pre;
        full_pre  = (sb.size() == Depth);
        empty_pre = (sb.size() == 0);
        if (fl) begin
            sb.delete();
            m_ovf = 1'b0;
        end else begin
            if (rd) begin
                if (empty_pre) begin
                    exp_rd    = 16'h0000;
                    exp_empty = 1'b1;
                end else begin
                    exp_rd    = sb.pop_front();
                    exp_empty = 1'b0;
                end
            end
            if (wr) begin
                if (full_pre) begin
`ifdef KBFIFO_OVERFLOW_EN
                    m_ovf = 1'b1;
`endif
                end else begin
                    sb.push_back(wd);
                end
            end
        end
        bus.wr_en  = wr;
        bus.wrdata = wd;
        bus.rd_en  = rd;
        bus.flush  = fl;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.flush = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        exp_rd    = 16'h0000;
        exp_empty = 1'b1;
        m_ovf     = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.count !== 5'd0) begin errors++;
            $display("FAIL reset_count: got %0d want 0", bus.count); end
        checks++; if (bus.full !== 1'b0) begin errors++;
            $display("FAIL reset_full: got %b want 0", bus.full); end
        checks++; if (bus.rd_empty !== 1'b1) begin errors++;
            $display("FAIL reset_rd_empty: got %b want 1", bus.rd_empty); end
        checks++; if (bus.rddata !== 16'h0000) begin errors++;
            $display("FAIL reset_rddata: got %h want 0000", bus.rddata); end
        checks++; if (bus.overflow !== 1'b0) begin errors++;
            $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
        op(1'b0, 16'h0, 1'b1, 1'b0);
        checks++; if (bus.rddata !== 16'h0000 || bus.rd_empty !== 1'b1) begin errors++;
            $display("FAIL reset_pop: got %h/%b want 0000/1", bus.rddata, bus.rd_empty); end
    endtask

    task automatic test_basic();
        do_reset();
        op(1'b1, 16'h0041, 1'b0, 1'b0);
        op(1'b1, 16'h0042, 1'b0, 1'b0);
        checks++; if (bus.count !== 5'd2) begin errors++;
            $display("FAIL basic_count: got %0d want 2", bus.count); end
        for (int i = 0; i < 3; i++) begin
            op(1'b0, 16'h0, 1'b1, 1'b0);
            checks++; if (bus.rddata !== exp_rd || bus.rd_empty !== exp_empty) begin errors++;
                $display("FAIL basic_pop%0d: got %h/%b want %h/%b",
                         i, bus.rddata, bus.rd_empty, exp_rd, exp_empty); end
        end
        checks++; if (bus.rddata !== 16'h0000 || bus.rd_empty !== 1'b1) begin errors++;
            $display("FAIL basic_third_pop: got %h/%b want 0000/1", bus.rddata, bus.rd_empty); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 5; i++) op(1'b1, 16'h7700 + 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) op(1'b0, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < Depth; i++) op(1'b1, 16'hA000 + 16'(i * 3), 1'b0, 1'b0);
        checks++; if (bus.full !== 1'b1 || bus.count !== 5'd16) begin errors++;
            $display("FAIL wrap_full: got full=%b count=%0d want 1/16", bus.full, bus.count); end
        op(1'b1, 16'hDEAD, 1'b0, 1'b0);
        checks++; if (bus.full !== 1'b1 || bus.count !== 5'd16) begin errors++;
            $display("FAIL wrap_drop: got full=%b count=%0d want 1/16", bus.full, bus.count); end
        checks++; if (bus.overflow !== m_ovf) begin errors++;
            $display("FAIL wrap_overflow: got %b want %b", bus.overflow, m_ovf); end
        for (int i = 0; i < Depth; i++) begin
            op(1'b0, 16'h0, 1'b1, 1'b0);
            checks++; if (bus.rddata !== exp_rd || bus.rd_empty !== 1'b0) begin errors++;
                $display("FAIL wrap_pop%0d: got %h/%b want %h/0",
                         i, bus.rddata, bus.rd_empty, exp_rd); end
        end
        checks++; if (bus.count !== 5'd0 || bus.full !== 1'b0) begin errors++;
            $display("FAIL wrap_drained: got count=%0d full=%b want 0/0", bus.count, bus.full); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < Depth; i++) op(1'b1, 16'h1100 + 16'(i), 1'b0, 1'b0);
        op(1'b1, 16'hBEEF, 1'b1, 1'b0);
        checks++; if (bus.rddata !== 16'h1100 || bus.rd_empty !== 1'b0) begin errors++;
            $display("FAIL fullpp_head: got %h/%b want 1100/0", bus.rddata, bus.rd_empty); end
        checks++; if (bus.count !== 5'd15 || bus.full !== 1'b0) begin errors++;
            $display("FAIL fullpp_count: got %0d full=%b want 15/0", bus.count, bus.full); end
        checks++; if (bus.overflow !== m_ovf) begin errors++;
            $display("FAIL fullpp_overflow: got %b want %b", bus.overflow, m_ovf); end
        for (int i = 0; i < 16; i++) begin
            op(1'b0, 16'h0, 1'b1, 1'b0);
            checks++; if (bus.rddata !== exp_rd || bus.rd_empty !== exp_empty) begin errors++;
                $display("FAIL fullpp_drain%0d: got %h/%b want %h/%b",
                         i, bus.rddata, bus.rd_empty, exp_rd, exp_empty); end
        end
    endtask

    task automatic test_empty_push_pop();
        do_reset();
        op(1'b1, 16'h1234, 1'b1, 1'b0);
        checks++; if (bus.rd_empty !== 1'b1 || bus.rddata !== 16'h0000) begin errors++;
            $display("FAIL emptypp_pop: got %h/%b want 0000/1", bus.rddata, bus.rd_empty); end
        checks++; if (bus.count !== 5'd1) begin errors++;
            $display("FAIL emptypp_count: got %0d want 1", bus.count); end
        op(1'b0, 16'h0, 1'b1, 1'b0);
        checks++; if (bus.rddata !== 16'h1234 || bus.rd_empty !== 1'b0) begin errors++;
            $display("FAIL emptypp_next: got %h/%b want 1234/0", bus.rddata, bus.rd_empty); end
    endtask

    task automatic test_flush();
        logic [15:0] held;
        do_reset();
        for (int i = 0; i < Depth; i++) op(1'b1, 16'h5500 + 16'(i), 1'b0, 1'b0);
        op(1'b1, 16'hCAFE, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) op(1'b0, 16'h0, 1'b1, 1'b0);
        checks++; if (bus.count !== 5'd5 || bus.overflow !== m_ovf) begin errors++;
            $display("FAIL flush_pre: got count=%0d ovf=%b want 5/%b",
                     bus.count, bus.overflow, m_ovf); end
        held = bus.rddata;
        checks++; if (held !== 16'h550A) begin errors++;
            $display("FAIL flush_pre_rddata: got %h want 550a", held); end
        op(1'b1, 16'h9999, 1'b1, 1'b1);
        checks++; if (bus.count !== 5'd0 || bus.overflow !== 1'b0) begin errors++;
            $display("FAIL flush_state: got count=%0d ovf=%b want 0/0", bus.count, bus.overflow); end
        checks++; if (bus.rddata !== 16'h550A || bus.rd_empty !== 1'b0) begin errors++;
            $display("FAIL flush_hold: got %h/%b want 550a/0", bus.rddata, bus.rd_empty); end
        op(1'b0, 16'h0, 1'b1, 1'b0);
        checks++; if (bus.rd_empty !== 1'b1 || bus.rddata !== 16'h0000) begin errors++;
            $display("FAIL flush_next_pop: got %h/%b want 0000/1", bus.rddata, bus.rd_empty); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) op(1'b1, 16'h3300 + 16'(i), 1'b0, 1'b0);
        op(1'b0, 16'h0, 1'b1, 1'b0);
        bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.wrdata = 16'h4444;
        do_reset();
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        checks++; if (bus.count !== 5'd0 || bus.rd_empty !== 1'b1 || bus.rddata !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid: got count=%0d %h/%b want 0 0000/1",
                     bus.count, bus.rddata, bus.rd_empty); end
    endtask

    task automatic test_back_to_back();
        logic wr, rd, fl;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ((i / 50) % 2 == 0) begin
                wr = ($urandom_range(0, 3) != 0);
                rd = ($urandom_range(0, 3) == 0);
            end else begin
                wr = ($urandom_range(0, 3) == 0);
                rd = ($urandom_range(0, 3) != 0);
            end
            fl = ($urandom_range(0, 59) == 0);
            op(wr, 16'($urandom), rd, fl);
            checks++;
            if (bus.rddata !== exp_rd || bus.rd_empty !== exp_empty
                || bus.count !== 5'(sb.size()) || bus.full !== (sb.size() == Depth)
                || bus.overflow !== m_ovf) begin
                errors++;
                $display("FAIL b2b_%0d: got %h/%b cnt=%0d full=%b ovf=%b want %h/%b cnt=%0d ovf=%b",
                         i, bus.rddata, bus.rd_empty, bus.count, bus.full, bus.overflow,
                         exp_rd, exp_empty, sb.size(), m_ovf);
            end
        end
    endtask

    initial begin
        bus.wr_en  = 1'b0;
        bus.rd_en  = 1'b0;
        bus.flush  = 1'b0;
        bus.wrdata = 16'h0;
        test_reset();
        test_basic();
        test_full_wrap();
        test_full_push_pop();
        test_empty_push_pop();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
